sha512_pad: RTL and testbench
=============================

# sha512_pad

Byte-stream message padder for the SHA-512 datapath, directly upstream of the per-chunk compression stage. It accepts a message one byte per cycle and applies SHA-512 padding: a 0x80 byte, zero fill, and a 128-bit big-endian bit length. It emits the result as 1024-bit chunks over a valid/ready handshake, with a last-chunk flag, so that the chunk sequencer can load each chunk into the compression stage in order.

## Interface
- CNT_W, default 64: width of the message byte counter. Messages of 2^CNT_W bytes or more are out of scope.
- clk  in  1  clock
- breset  in  1  asynchronous active-low reset
- in_data  in  8  message byte
- in_keep  in  1  1 = in_data is a message byte; 0 = beat carries no byte (used for an empty message)
- in_last  in  1  final beat of the message
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- chunk_data  out  1024  padded chunk; the first message byte is at [1023:1016], big-endian 64-bit words
- chunk_last  out  1  final chunk of the message
- chunk_valid  out  1  chunk presented
- chunk_ready  in  1  chunk consumed when chunk_valid && chunk_ready

## Operation
- Registers:
  - state
  - buf[1024], the chunk buffer
  - idx[7], the byte slot 0..127
  - cnt[CNT_W], total bytes
  - pad_pending, needs_len, last_flag
- States: BIRTH, FILL, PAD, EMIT, LEN.
- Reset (async, breset low):
  - state=BIRTH, buf=0, idx=0, cnt=0, all flags 0.
  - Outputs: in_ready=0, chunk_valid=0, chunk_last=0, chunk_data=0.
  - Reset asserted mid-message abandons all state; no partial chunk is ever emitted.
- BIRTH → FILL unconditionally after one cycle.
- FILL: in_ready=1.
  - An accepted beat with keep=1 writes buf byte idx, then idx+=1 and cnt+=1.
  - An accepted beat with keep=0 stores nothing.
  - Non-last beat that filled slot 127 → EMIT, chunk non-last.
  - Last beat, buffer now full → EMIT non-last with pad_pending=1.
  - Last beat, buffer not full → PAD.
- PAD: one cycle, in_ready=0. Let p = idx.
  - buf[p]=0x80; bytes above p are already zero.
  - If p≤111: buf[127:0]={cnt,3'b000} zero-extended to 128 bits, last_flag=1.
  - If p≥112: needs_len=1, last_flag=0.
  - Always → EMIT.
- EMIT: chunk_valid=1, chunk_data=buf, chunk_last=last_flag. On handshake: buf=0, idx=0, then branch:
  - last_flag → FILL, with cnt and all flags cleared.
  - pad_pending → PAD (0x80 at byte 0, length, last).
  - needs_len → LEN.
  - Otherwise → FILL.
- LEN: one cycle. buf[127:0]=bit length, last_flag=1, needs_len=0 → EMIT.
- Bit length is cnt·8, computed modulo 2^128. Upper bits are zero when CNT_W<125.

## Timing
- Input throughput: 1 byte/cycle in FILL.
- A full non-last chunk whose 128th byte is accepted in cycle t has chunk_valid=1 at t+1.
- A last byte accepted in cycle t, with p≤111, has its final chunk valid at t+2 (the extra cycle is PAD).
- Extra-chunk paths, measured from the first chunk's handshake at cycle h:
  - p≥112: the second chunk is valid at h+2 (via LEN).
  - Full last chunk: the second chunk is valid at h+2 (via PAD).
- chunk_data and chunk_last hold stable while chunk_valid && !chunk_ready.
- chunk_valid never drops without a handshake.
- in_ready=0 in every state except FILL, so no byte is accepted during emission.

## Structure
- Shared package sha512_pkg holds:
  - the state enum
  - CHUNK_BITS=1024, LEN_BITS=128, LEN_OFFSET=112
  - PAD_BYTE=8'h80
- The same package also holds the round constants used by the compression stage.
- Single module, no sub-module; buffer byte writes use an indexed part-select.

## Test plan
- Empty message (single beat: keep=0, last=1) → one chunk: [1023:1016]=8'h80, all other bits 0, chunk_last=1.
- "abc" (0x61,0x62,0x63, last on 0x63) → one chunk: [1023:992]=32'h61626380, [127:0]=24, remaining bits 0, last=1, valid 2 cycles after the last byte.
- 112 bytes 0x00..0x6F → two chunks:
  - Chunk 1: bytes 0..111 data, byte 112=0x80, rest 0, last=0.
  - Chunk 2: zero except [127:0]=896, last=1.
- 128 bytes → two chunks:
  - Chunk 1: all data, last=0.
  - Chunk 2: byte 0=0x80, [127:0]=1024, last=1.
- chunk_ready held low for 5 cycles on each chunk of a 200-byte message:
  - chunk_data is stable and in_ready=0 throughout the stall.
  - Chunk 1 is bytes 0..127.
  - Chunk 2 is bytes 128..199, then 0x80, with [127:0]=1600, last=1.
- breset pulsed after 50 bytes of a message:
  - All outputs read 0 during reset.
  - in_ready rises 1 cycle after release.
  - A following "abc" yields exactly the chunk from the "abc" scenario.

Source files
------------

// File: rtl/sha512_pkg.sv
// Shared SHA-512 definitions: padder state encoding, chunk geometry and the
// round constants consumed by the compression stage.
package sha512_pkg;

  typedef enum logic [2:0] {
    BIRTH,
    FILL,
    PAD,
    EMIT,
    LEN
  } state_t;

  localparam int CHUNK_BITS = 1024;
  localparam int LEN_BITS   = 128;
  localparam int LEN_OFFSET = 112;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

endpackage

// File: rtl/sha512_pad_if.sv
// Byte-in / chunk-out handshake bundle of the SHA-512 padder.
interface sha512_pad_if;

  logic [7:0]                       in_data;
  logic                             in_keep;
  logic                             in_last;
  logic                             in_valid;
  logic                             in_ready;
  logic [sha512_pkg::CHUNK_BITS-1:0] chunk_data;
  logic                             chunk_last;
  logic                             chunk_valid;
  logic                             chunk_ready;

  modport slave (
    input  in_data, in_keep, in_last, in_valid, chunk_ready,
    output in_ready, chunk_data, chunk_last, chunk_valid
  );

  modport master (
    output in_data, in_keep, in_last, in_valid, chunk_ready,
    input  in_ready, chunk_data, chunk_last, chunk_valid
  );

endinterface

// File: rtl/sha512_pad.sv
// SHA-512 message padder: packs a byte stream into 1024-bit chunks and appends
// the 0x80 marker, zero fill and 128-bit big-endian bit length.
module sha512_pad
  import sha512_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input logic         clk,
  input logic         breset,
  sha512_pad_if.slave bus
);

  state_t                state_reg, state_next;
  logic [CHUNK_BITS-1:0] buf_reg;
  logic [6:0]            idx_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  pad_pending_reg;
  logic                  needs_len_reg;
  logic                  last_flag_reg;

  logic                  in_fire;
  logic                  slot_full;
  logic [9:0]            slot_lsb;
  logic [LEN_BITS-1:0]   bit_len;

  assign in_fire   = (state_reg == FILL) && bus.in_valid;
  assign slot_full = bus.in_keep && (idx_reg == 7'd127);
  // Slot 0 sits in the most significant byte of the chunk.
  assign slot_lsb  = 10'(CHUNK_BITS - 8) - {idx_reg, 3'b000};
  assign bit_len   = LEN_BITS'({cnt_reg, 3'b000});

  always_ff @(posedge clk or negedge breset) begin
    if (!breset) state_reg <= BIRTH;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next      = state_reg;
    bus.in_ready    = 1'b0;
    bus.chunk_valid = 1'b0;
    bus.chunk_last  = 1'b0;
    bus.chunk_data  = buf_reg;
    case (state_reg)
      BIRTH: state_next = FILL;
      FILL: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (slot_full)        state_next = EMIT;
          else if (bus.in_last) state_next = PAD;
        end
      end
      PAD:   state_next = EMIT;
      LEN:   state_next = EMIT;
      EMIT: begin
        bus.chunk_valid = 1'b1;
        bus.chunk_last  = last_flag_reg;
        if (bus.chunk_ready) begin
          if (last_flag_reg)        state_next = FILL;
          else if (pad_pending_reg) state_next = PAD;
          else if (needs_len_reg)   state_next = LEN;
          else                      state_next = FILL;
        end
      end
      default: state_next = BIRTH;
    endcase
  end

  always_ff @(posedge clk or negedge breset) begin
    if (!breset) begin
      buf_reg         <= '0;
      idx_reg         <= '0;
      cnt_reg         <= '0;
      pad_pending_reg <= 1'b0;
      needs_len_reg   <= 1'b0;
      last_flag_reg   <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (in_fire) begin
            if (bus.in_keep) begin
              buf_reg[slot_lsb +: 8] <= bus.in_data;
              idx_reg                <= idx_reg + 7'd1;
              cnt_reg                <= cnt_reg + CNT_W'(1);
            end
            // A last byte that fills the chunk leaves no room for the marker.
            if (slot_full && bus.in_last) pad_pending_reg <= 1'b1;
          end
        end
        PAD: begin
          buf_reg[slot_lsb +: 8] <= PAD_BYTE;
          pad_pending_reg        <= 1'b0;
          if (idx_reg < 7'(LEN_OFFSET)) begin
            buf_reg[LEN_BITS-1:0] <= bit_len;
            last_flag_reg         <= 1'b1;
          end else begin
            needs_len_reg <= 1'b1;
          end
        end
        LEN: begin
          buf_reg[LEN_BITS-1:0] <= bit_len;
          last_flag_reg         <= 1'b1;
          needs_len_reg         <= 1'b0;
        end
        EMIT: begin
          if (bus.chunk_ready) begin
            buf_reg <= '0;
            idx_reg <= '0;
            if (last_flag_reg) begin
              cnt_reg         <= '0;
              last_flag_reg   <= 1'b0;
              pad_pending_reg <= 1'b0;
              needs_len_reg   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha512_pad.sv
// Self-checking bench for sha512_pad: scoreboard of reference padded chunks,
// latency, stall stability and reset behaviour.
module tb_sha512_pad;
  import sha512_pkg::*;

  typedef logic [7:0] bytes_t[$];
  typedef struct packed {
    logic [CHUNK_BITS-1:0] data;
    logic                  last;
  } exp_t;

  logic clk = 1'b0;
  logic breset = 1'b0;
  always #5 clk = ~clk;

  sha512_pad_if bus ();

  sha512_pad #(.CNT_W(64)) dut (
    .clk   (clk),
    .breset(breset),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int seen_cyc[$];
  int hs_cyc[$];
  bit abort_drv = 0;
  logic [CHUNK_BITS-1:0] last_chunk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference padding: message, 0x80, zeros to 112 mod 128, 128-bit bit length.
  function automatic void push_expected(input bytes_t msg);
    bytes_t s;
    logic [127:0] bl;
    exp_t e;
    int n;
    s = msg;
    bl = 128'(msg.size()) << 3;
    s.push_back(8'h80);
    while ((s.size() % 128) != 112) s.push_back(8'h00);
    for (int i = 15; i >= 0; i--) s.push_back(bl[8*i +: 8]);
    n = s.size() / 128;
    for (int c = 0; c < n; c++) begin
      e.data = '0;
      for (int b = 0; b < 128; b++) e.data[CHUNK_BITS-1-8*b -: 8] = s[c*128+b];
      e.last = (c == n - 1);
      exp_q.push_back(e);
    end
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic k, input logic l);
    int waited = 0;
    bit ok = 0;
    if (abort_drv) return;
    bus.in_data  = d;
    bus.in_keep  = k;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    while (!ok) begin
      #1;
      if (bus.in_ready) begin
        ok = 1;
        if (l) last_acc_cyc = cyc;
      end
      @(negedge clk);
      if (!ok) begin
        waited++;
        if (waited > 3000) begin
          checks++; failures++;
          $display("FAIL in_ready_timeout got=0 required=1 within 3000 cycles");
          abort_drv = 1;
          bus.in_valid = 1'b0;
          return;
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drive_msg(input bytes_t msg);
    if (msg.size() == 0) send_beat(8'h00, 1'b0, 1'b1);
    else for (int i = 0; i < msg.size(); i++) send_beat(msg[i], 1'b1, i == msg.size() - 1);
  endtask

  task automatic collect(input int n, input bit stall);
    exp_t e;
    logic [CHUNK_BITS-1:0] snap;
    logic snap_last;
    int waited;
    int fb;
    for (int k = 0; k < n; k++) begin
      waited = 0;
      #1;
      while (!bus.chunk_valid) begin
        @(negedge clk); #1;
        waited++;
        if (waited > 3000) begin
          checks++; failures++;
          $display("FAIL chunk_valid_timeout chunk=%0d got=0 required=1", k);
          return;
        end
      end
      seen_cyc.push_back(cyc);
      if (stall) begin
        snap = bus.chunk_data;
        snap_last = bus.chunk_last;
        repeat (5) begin
          @(negedge clk); #1;
          checks++;
          if (bus.chunk_valid !== 1'b1 || bus.chunk_data !== snap || bus.chunk_last !== snap_last) begin
            failures++;
            $display("FAIL stall_stable chunk=%0d valid=%b low_got=%h low_required=%h", k,
                     bus.chunk_valid, bus.chunk_data[63:0], snap[63:0]);
          end
          checks++;
          if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_in_ready chunk=%0d got=%b required=0", k, bus.in_ready);
          end
        end
      end
      hs_cyc.push_back(cyc);
      bus.chunk_ready = 1'b1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_chunk chunk=%0d got=extra required=none", k);
      end else begin
        e = exp_q.pop_front();
        if (bus.chunk_data !== e.data) begin
          failures++;
          fb = -1;
          for (int b = 127; b >= 0; b--)
            if (bus.chunk_data[CHUNK_BITS-1-8*b -: 8] !== e.data[CHUNK_BITS-1-8*b -: 8]) fb = b;
          $display("FAIL chunk_data chunk=%0d first_bad_byte=%0d got=%h required=%h", k, fb,
                   bus.chunk_data[CHUNK_BITS-1-8*fb -: 8], e.data[CHUNK_BITS-1-8*fb -: 8]);
        end
        checks++;
        if (bus.chunk_last !== e.last) begin
          failures++;
          $display("FAIL chunk_last chunk=%0d got=%b required=%b", k, bus.chunk_last, e.last);
        end
      end
      last_chunk = bus.chunk_data;
      $display("chunk %0d at cycle %0d last=%b", k, cyc, bus.chunk_last);
      @(negedge clk);
      bus.chunk_ready = 1'b0;
    end
  endtask

  task automatic run_scenario(input string name, input bytes_t msg, input bit stall);
    int n;
    @(negedge clk);
    abort_drv = 0;
    exp_q.delete();
    seen_cyc.delete();
    hs_cyc.delete();
    push_expected(msg);
    n = exp_q.size();
    fork
      drive_msg(msg);
      collect(n, stall);
    join
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.chunk_valid !== 1'b0 || bus.in_ready !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_idle valid=%b in_ready=%b pending=%0d required valid=0 in_ready=1 pending=0",
               name, bus.chunk_valid, bus.in_ready, exp_q.size());
    end
    $display("scenario %s: %0d bytes, %0d chunks", name, msg.size(), n);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.chunk_valid !== 1'b0 || bus.chunk_last !== 1'b0 ||
        bus.chunk_data !== '0) begin
      failures++;
      $display("FAIL %s in_ready=%b valid=%b last=%b data_nonzero=%b required all 0", name,
               bus.in_ready, bus.chunk_valid, bus.chunk_last, |bus.chunk_data);
    end
  endtask

  task automatic release_reset(input string name);
    @(negedge clk);
    breset = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_ready_at_release got=%b required=0", name, bus.in_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_after_release got=%b required=1", name, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    breset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset_outputs");
    release_reset("reset");
  endtask

  task automatic test_empty();
    bytes_t m;
    run_scenario("empty", m, 1'b0);
    checks++;
    if (last_chunk[CHUNK_BITS-1 -: 8] !== 8'h80 || last_chunk[CHUNK_BITS-9:0] !== '0) begin
      failures++;
      $display("FAIL empty_literal top=%h rest_nonzero=%b required top=80 rest=0",
               last_chunk[CHUNK_BITS-1 -: 8], |last_chunk[CHUNK_BITS-9:0]);
    end
  endtask

  task automatic test_abc(input string name);
    bytes_t m;
    m = '{8'h61, 8'h62, 8'h63};
    run_scenario(name, m, 1'b0);
    checks++;
    if (last_chunk[1023:992] !== 32'h61626380 || last_chunk[127:0] !== 128'd24) begin
      failures++;
      $display("FAIL %s_literal head=%h len=%0d required head=61626380 len=24", name,
               last_chunk[1023:992], last_chunk[127:0]);
    end
    if (seen_cyc.size() >= 1) begin
      checks++;
      if (seen_cyc[0] - last_acc_cyc != 2) begin
        failures++;
        $display("FAIL %s_latency got=%0d required=2", name, seen_cyc[0] - last_acc_cyc);
      end
    end
  endtask

  task automatic test_len_boundary();
    bytes_t m;
    for (int i = 0; i < 112; i++) m.push_back(8'(i));
    run_scenario("len112", m, 1'b0);
    if (seen_cyc.size() >= 2) begin
      checks++;
      if (seen_cyc[0] - last_acc_cyc != 2) begin
        failures++;
        $display("FAIL len112_first_latency got=%0d required=2", seen_cyc[0] - last_acc_cyc);
      end
      checks++;
      if (seen_cyc[1] - hs_cyc[0] != 2) begin
        failures++;
        $display("FAIL len112_second_latency got=%0d required=2", seen_cyc[1] - hs_cyc[0]);
      end
    end
  endtask

  task automatic test_full_chunk();
    bytes_t m;
    for (int i = 0; i < 128; i++) m.push_back(8'(255 - i));
    run_scenario("full128", m, 1'b0);
    if (seen_cyc.size() >= 2) begin
      checks++;
      if (seen_cyc[0] - last_acc_cyc != 1) begin
        failures++;
        $display("FAIL full128_first_latency got=%0d required=1", seen_cyc[0] - last_acc_cyc);
      end
      checks++;
      if (seen_cyc[1] - hs_cyc[0] != 2) begin
        failures++;
        $display("FAIL full128_second_latency got=%0d required=2", seen_cyc[1] - hs_cyc[0]);
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    bytes_t m;
    for (int i = 0; i < 200; i++) m.push_back(8'((i * 7 + 3) & 8'hff));
    run_scenario("stall200", m, 1'b1);
    checks++;
    if (last_chunk[127:0] !== 128'd1600) begin
      failures++;
      $display("FAIL stall200_len got=%0d required=1600", last_chunk[127:0]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    abort_drv = 0;
    for (int i = 0; i < 50; i++) send_beat(8'(i + 1), 1'b1, 1'b0);
    breset = 1'b0;
    #1;
    check_reset_outputs("midreset_outputs");
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("midreset_hold");
    release_reset("midreset");
    test_abc("abc_after_reset");
  endtask

  initial begin
    bus.in_data     = 8'h00;
    bus.in_keep     = 1'b0;
    bus.in_last     = 1'b0;
    bus.in_valid    = 1'b0;
    bus.chunk_ready = 1'b0;
    test_reset();
    test_empty();
    test_abc("abc");
    test_len_boundary();
    test_full_chunk();
    test_back_to_back_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
